// File: rtl/lmem_load_streamer.sv
// lmem_load_streamer: packs channel LLR rows into Lmem load words, padding rows >= Z; a fixed count of words per frame.
// Optional input saturation to W bits when LOAD_SAT_EN is defined.
module lmem_load_streamer #(
    parameter int W            = 6,
    parameter int WIN          = 6,
    parameter int Nb           = 16,
    parameter int Z            = 511,
    parameter int ROWSPERWORD  = 32,
    parameter int LOADWORDS    = 17,
    parameter int ROWCNTWIDTH  = 10,
    parameter int WORDCNTWIDTH = 5,
    parameter int PADVAL       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [Nb*WIN-1:0]             in_llr,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [ROWSPERWORD*Nb*W-1:0]   load_data,
    output logic                          loaden,
    output logic                          busy,
    output logic                          load_done,
    output logic                          frame_err
);
    localparam int NW = Nb * W;
    localparam int SW = $clog2(ROWSPERWORD);
    localparam logic [W-1:0] PAD_W = W'(PADVAL);

    typedef enum logic [2:0] {IDLE, FILL, PAD, EMIT, DONE} state_t;

    state_t                     state, next;
    logic [ROWCNTWIDTH-1:0]     row_cnt;
    logic [WORDCNTWIDTH-1:0]    word_cnt;
    logic [SW-1:0]              slot;
    logic [ROWSPERWORD*NW-1:0]  buffer, nbuf;
    logic [NW-1:0]              row_w, wr_row;
    logic                       accept, wr, last_slot, last_row, last_word;

`ifdef LOAD_SAT_EN
    localparam logic signed [WIN-1:0] SMAX = WIN'((1 << (W-1)) - 1);
    localparam logic signed [WIN-1:0] SMIN = -SMAX;
    for (genvar c = 0; c < Nb; c++) begin : g_sat
        logic signed [WIN-1:0] v;
        assign v = in_llr[c*WIN +: WIN];
        assign row_w[c*W +: W] = v > SMAX ? SMAX[W-1:0] : v < SMIN ? SMIN[W-1:0] : v[W-1:0];
    end
`else
    assign row_w = in_llr;
`endif

    assign in_ready  = state == FILL;
    assign loaden    = state == EMIT;
    assign busy      = state != IDLE;
    assign load_done = state == DONE;
    assign accept    = in_valid && in_ready;
    assign wr        = accept || state == PAD;
    assign wr_row    = state == PAD ? {Nb{PAD_W}} : row_w;
    assign last_slot = slot == SW'(ROWSPERWORD - 1);
    assign last_row  = row_cnt == ROWCNTWIDTH'(Z - 1);
    assign last_word = word_cnt == WORDCNTWIDTH'(LOADWORDS - 1);

    always_comb begin
        nbuf = buffer;
        if (wr) nbuf[int'(slot)*NW +: NW] = wr_row;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? FILL : IDLE;
            FILL:    next = !accept ? FILL : last_slot ? EMIT : last_row ? PAD : FILL;
            PAD:     next = last_slot ? EMIT : PAD;
            EMIT:    next = last_word ? DONE : row_cnt >= ROWCNTWIDTH'(Z) ? PAD : FILL;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            word_cnt  <= '0;
            slot      <= '0;
            buffer    <= '0;
            load_data <= '0;
            frame_err <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && start) begin
                row_cnt   <= '0;
                word_cnt  <= '0;
                slot      <= '0;
                frame_err <= 1'b0;
            end
            if (wr) begin
                buffer  <= nbuf;
                row_cnt <= row_cnt + 1'b1;
                slot    <= last_slot ? '0 : slot + 1'b1;
            end
            // The completing row lands in load_data on the same edge that enters EMIT.
            if (wr && next == EMIT) load_data <= nbuf;
            if (state == EMIT) word_cnt <= word_cnt + 1'b1;
            if (accept && (in_last != last_row)) frame_err <= 1'b1;
        end
    end
endmodule

// File: doc/lmem_load_streamer.md
Name: lmem_load_streamer

Overview:
- Transmit side of the Lmem codeword-load interface. Accepts channel LLRs one circulant row per beat (all Nb circulants side by side) over a valid/ready stream.
- Packs ROWSPERWORD rows into one load_data word and drives loaden/load_data into the bit-node memory.
- Pads rows at index Z and above, and emits exactly LOADWORDS words per frame, in row order.
- Sits between the channel input interface and Lmem's load_data/loaden port, under control of the Agen controller (start/load_done).

Parameters:
- W, 6, LLR width stored in Lmem.
- WIN, 6, input LLR width; must equal W unless LOAD_SAT_EN is defined.
- Nb, 16, circulant blocks per layer.
- Z, 511, circulant size (real rows per frame).
- ROWSPERWORD, 32, rows per load word.
- LOADWORDS, 17, load words per frame; requires LOADWORDS*ROWSPERWORD >= Z.
- ROWCNTWIDTH, 10, row counter width.
- WORDCNTWIDTH, 5, word counter width.
- PADVAL, 0, W-bit value written into pad rows.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle frame start request; honoured only in IDLE.
- in_llr, in, Nb*WIN, one row: circulant c occupies bits [c*WIN +: WIN].
- in_valid, in, 1, in_llr valid.
- in_last, in, 1, marks the final real row (row Z-1).
- in_ready, out, 1, streamer accepts the beat this cycle.
- load_data, out, ROWSPERWORD*Nb*W, packed word: row j at [j*Nb*W +: Nb*W], circulant c at [c*W +: W] within the row.
- loaden, out, 1, load_data valid; one cycle per word.
- busy, out, 1, high in every state except IDLE.
- load_done, out, 1, one-cycle pulse after the last word is emitted.
- frame_err, out, 1, sticky; set when in_last does not coincide with row Z-1; cleared on start.

Behaviour:
- Reset (asynchronous): state=IDLE; all counters 0; load_data=0; loaden=0; in_ready=0; busy=0; load_done=0; frame_err=0. Reset mid-frame abandons the frame; no further loaden.
- Beat accepted when in_valid && in_ready. Each accepted beat is written into pack buffer slot j (row_cnt mod ROWSPERWORD). row_cnt increments on every accept and every pad insert.
- States:
  - IDLE: in_ready=0. On start: clear counters and frame_err, go to FILL.
  - FILL: in_ready=1. On accept with j==ROWSPERWORD-1, go to EMIT. On accept of row Z-1 with j<ROWSPERWORD-1, go to PAD.
  - PAD: in_ready=0. Write PADVAL into slot j, one row per cycle, until j==ROWSPERWORD-1 is written; then go to EMIT.
  - EMIT: in_ready=0; loaden=1 for exactly this cycle; load_data holds the registered buffer. Then:
    - word_cnt==LOADWORDS-1: go to DONE.
    - otherwise, row_cnt>=Z: go to PAD (whole pad word).
    - otherwise: go to FILL.
  - DONE: load_done=1 for one cycle; go to IDLE.
- load_data is registered and holds its value outside EMIT. Lmem advances its load address only on loaden, so gaps between words are legal.
- Latency: loaden is asserted in the cycle after the accept or pad that completes a word.
- Defaults (Z=511): words 0–14 are fully real. Word 15 carries rows 480–510 plus 1 pad row. Word 16 is all pad. Total 544 rows, 33 pad.
- Boundary conditions:
  - start outside IDLE: ignored.
  - in_valid outside FILL: not accepted, no side effect.
  - in_last on a row other than Z-1: set frame_err; framing continues by count.
  - No in_last on row Z-1: set frame_err.
  - The streamer never accepts more than Z beats per frame.

Optional Feature:
- Macro: LOAD_SAT_EN.
- Defined: each WIN-bit two's-complement input LLR is saturated to the W-bit range.
  - Values above 2^(W-1)-1 become 2^(W-1)-1 (maxVal, 6'b011111 at W=6).
  - Values below -(2^(W-1)-1) become -(2^(W-1)-1).
  - Saturation is combinational before the buffer write; no added latency.
- Undefined: WIN must equal W; LLRs pass unchanged.

Test Plan:
- Full frame, in_valid always 1: row r, circulant c value = (r+c) mod 32 → exactly 17 loaden pulses. Pulses 0–14 are spaced 33 cycles apart. Word 15 slot 31 = 0. Word 16 = all 0. load_done is 1 cycle after the 17th loaden; frame_err=0.
- Backpressure: in_valid toggles 1,0 → same 17 words bit-exact to the first test; no duplicate or dropped rows.
- start pulsed mid-frame at row 100 → ignored; output identical to the first test. in_last asserted at row 300 → frame_err=1 and stays 1 until the next start.
- rst raised at row 250 (during word 7) → all outputs 0 within the reset cycle. A new start then produces a clean 17-word frame.
- LOAD_SAT_EN, WIN=8, W=6: inputs 8'sd100, -8'sd100, 8'sd5 → stored 6'b011111, 6'b100001, 6'b000101.
